apb_interface: RTL and testbench
================================

Name: apb_interface

Overview:
- Self-contained APB subsystem: a simple command port drives an internal APB master FSM, which performs one APB transfer per request to an internal APB slave.
- The slave is a word-addressed register memory with a fixed number of wait states.
- Used as a bring-up/verification block for the APB-to-APB bridge: single-word writes and reads, with read data returned on a held output.

Parameters:
- BASE_ADDR, 32'h0000_0000: first valid word address of the slave memory.
- ADDR_WIDTH, 32: width of address and paddr.
- DATA_WIDTH, 32: width of wdata/rdata/pwdata/prdata.
- MEM_SIZE, 32: number of DATA_WIDTH words in the slave memory.
- WAIT_CYCLE, 3: wait states inserted by the slave (ACCESS cycles with pready=0) per transfer; 0 is legal.

Ports:
- clk, input, 1: single clock; all logic is on its rising edge.
- rst_n, input, 1: synchronous active-low reset.
- start, input, 1: transfer request; a 0->1 transition launches one transfer.
- wr, input, 1: 1=write, 0=read; sampled with start.
- address, input, ADDR_WIDTH: word address; sampled with start.
- wdata, input, DATA_WIDTH: write data; sampled with start.
- rdata, output, DATA_WIDTH: data of the last completed read, held until the next read completes.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; psel, penable, pwrite and paddr are cleared.
  - Wait counter and start_q are cleared.
  - All memory words are cleared to 0; rdata is 0.
  - Reset asserted mid-transfer aborts the transfer: no memory write, rdata becomes 0.
- Request detect: start_q registers start. A request is start=1 while start_q=0 and FSM=IDLE.
  - Level-held start does not retrigger.
  - Rising edges while not IDLE are ignored.
  - start already high when reset releases counts as a request.
- Command capture: at the request edge, wr, address and wdata are latched into pwrite, paddr and pwdata. The inputs may then change freely.
- Master FSM states and transitions:
  - IDLE: psel=0, penable=0. Moves to SETUP on a request.
  - SETUP: psel=1, penable=0. Lasts one cycle, then moves to ACCESS.
  - ACCESS: psel=1, penable=1. Holds until pready=1, then returns to IDLE with psel and penable dropping.
- Slave wait states:
  - The counter clears in SETUP and increments each ACCESS cycle while pready=0.
  - pready = psel & penable & (count == WAIT_CYCLE).
  - Each transfer has exactly WAIT_CYCLE stalled ACCESS cycles; WAIT_CYCLE=0 completes in the first ACCESS cycle.
- Latency: the completion edge is exactly WAIT_CYCLE+2 clk edges after the request edge (5 with defaults).
- Address decode:
  - In range when BASE_ADDR <= paddr < BASE_ADDR+MEM_SIZE; word index = paddr - BASE_ADDR.
  - Out-of-range transfers still complete with the same wait states, and pslverr=1 during the completing cycle.
- Completion edge actions:
  - Write, in range: mem[index] <= pwdata.
  - Write, out of range: discarded, memory unchanged.
  - Read, in range: rdata <= mem[index].
  - Read, out of range: rdata <= 0.
- rdata changes only at read completion or reset; it is unaffected by writes, including a write to the address last read.
- Last-address wrap: MEM_SIZE-1 is the last valid word; no wrap-around, so BASE_ADDR+MEM_SIZE is an error.

Test Plan:
- Reset for 5 cycles, then read address 0 -> rdata=0; memory-clear check on all 32 words -> each reads 0.
- For i=0..31, write 32'hDEAD_0000+i to address i, with start held WAIT_CYCLE+3 cycles and wr dropped after WAIT_CYCLE+1 cycles -> each write lands intact. Then read back i=0..31 -> rdata=32'hDEAD_0000+i, stable until the next read completes.
- Write 32'hDEAD_0020 to address 32, then read address 32 -> pslverr pulses, memory unchanged, rdata=0.
- Request edge at T -> psel rises T+1, penable rises T+2, pready rises T+5 (WAIT_CYCLE=3). Same with WAIT_CYCLE=0 -> completion at T+2.
- Hold start high for 20 cycles -> exactly one transfer. A second rising edge during ACCESS -> ignored.
- Assert rst_n=0 during ACCESS of a write to address 5 -> FSM IDLE, mem[5]=0, rdata=0 after reset.

Source files
------------

// File: rtl/apb_interface.sv
// apb_interface: a command port drives an internal APB master FSM. The FSM performs one
// transfer per request into an internal word-addressed APB slave memory that has fixed wait states.
module apb_interface #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MEM_SIZE   = 32,
    parameter int                    WAIT_CYCLE = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int CNT_W = (WAIT_CYCLE > 0) ? $clog2(WAIT_CYCLE + 1) : 1;
    localparam logic [CNT_W-1:0]      WAIT_VAL  = CNT_W'(WAIT_CYCLE);
    localparam logic [ADDR_WIDTH-1:0] MEM_WORDS = ADDR_WIDTH'(MEM_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_start_q;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

    logic                  w_request;
    logic                  w_psel;
    logic                  w_penable;
    logic                  w_pready;
    logic                  w_pslverr;
    logic                  w_in_range;
    logic [ADDR_WIDTH:0]   w_diff;
    logic [IDX_W-1:0]      w_index;

    // Only a 0->1 edge seen while IDLE starts a transfer. Held levels and edges mid-transfer are ignored.
    assign w_request = start & ~r_start_q & (r_state == IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first, so every path through the case assigns and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_request) w_next_state = SETUP;
            SETUP:   w_next_state = ACCESS;
            ACCESS:  if (w_pready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_psel    = 1'b0;
        w_penable = 1'b0;
        case (r_state)
            SETUP:   w_psel = 1'b1;
            ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
            end
            default: ;
        endcase
    end

    // Command capture. The inputs are free to change once the request edge has passed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state always uses <=, so every register samples pre-edge values.
            r_start_q <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            r_start_q <= start;
            if (w_request) begin
                r_pwrite <= wr;
                r_paddr  <= address;
                r_pwdata <= wdata;
            end
        end
    end

    // Slave wait-state counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_state == SETUP) begin
            r_count <= '0;
        end else if (r_state == ACCESS && !w_pready) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign w_pready = w_psel & w_penable & (r_count == WAIT_VAL);

    // The extra borrow bit flags addresses below BASE_ADDR, so no wrap-around can alias into range.
    assign w_diff     = {1'b0, r_paddr} - {1'b0, BASE_ADDR};
    assign w_in_range = ~w_diff[ADDR_WIDTH] & (w_diff[ADDR_WIDTH-1:0] < MEM_WORDS);
    assign w_index    = w_diff[IDX_W-1:0];
    assign w_pslverr  = w_pready & ~w_in_range;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: this memory is reset word by word because cleared contents are architecturally visible.
            for (int i = 0; i < MEM_SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_pready && r_pwrite && !w_pslverr) begin
            r_mem[w_index] <= r_pwdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_pready && !r_pwrite) begin
            r_rdata <= w_pslverr ? '0 : r_mem[w_index];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: tb/tb_apb_interface.sv
// Scoreboard bench for apb_interface. A model memory predicts each transfer's response, and a
// negedge monitor checks that response when the DUT completes.
module tb_apb_interface;

    localparam int W   = 3;
    localparam int MEM = 32;

    typedef struct packed {
        logic        is_rd;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, wr;
    logic [31:0] address, wdata, rdata;
    logic        start_z, wr_z;
    logic [31:0] address_z, wdata_z, rdata_z;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] hold_rdata;
    logic [31:0] mem_m [MEM];

    always #5 clk = ~clk;

    apb_interface #(.WAIT_CYCLE(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wr(wr),
        .address(address), .wdata(wdata), .rdata(rdata)
    );

    apb_interface #(.WAIT_CYCLE(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(start_z), .wr(wr_z),
        .address(address_z), .wdata(wdata_z), .rdata(rdata_z)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: rdata must stay at the last read result until the next read completes.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rdata_hold", rdata, hold_rdata);
            if (dut.w_pready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pslverr", {31'b0, dut.w_pslverr}, {31'b0, mon_e.err});
                    if (mon_e.is_rd) hold_rdata = mon_e.rd;
                end
            end
        end
    end

    function automatic exp_t predict(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_rd = ~w;
        e.err   = (a >= MEM);
        e.rd    = (!w && a < MEM) ? mem_m[a[4:0]] : 32'h0;
        if (w && a < MEM) mem_m[a[4:0]] = d;
        return e;
    endfunction

    task automatic wait_done();
        int k;
        for (k = 0; k < 60; k++) begin
            tick();
            if (exp_q.size() == 0 && !dut.w_psel) break;
        end
        check("done_in_time", {31'b0, k < 60}, 32'd1);
        if (k == 60) exp_q.delete();
        tick();
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int hold_cyc, input bit scramble);
        exp_q.push_back(predict(w, a, d));
        wr = w; address = a; wdata = d; start = 1'b1;
        for (int k = 0; k < hold_cyc; k++) begin
            tick();
            if (scramble && k == W) begin
                wr = ~w; address = $urandom; wdata = $urandom;
            end
        end
        start = 1'b0;
        wait_done();
    endtask

    // Negedge i after the request edge T shows the values the FSM presents to edge T+i.
    task automatic latency_check(input logic [31:0] a);
        exp_q.push_back(predict(1'b0, a, 32'h0));
        wr = 1'b0; address = a; start = 1'b1;
        tick();
        for (int i = 1; i <= W + 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            check($sformatf("timing_c%0d", i),
                  {29'b0, dut.w_psel, dut.w_penable, dut.w_pready},
                  {29'b0, i <= W + 2, i >= 2 && i <= W + 2, i == W + 2});
        end
        wait_done();
    endtask

    task automatic zop(input logic w, input logic [31:0] a, input logic [31:0] d, output int lat);
        wr_z = w; address_z = a; wdata_z = d; start_z = 1'b1;
        tick();
        start_z = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (dut_z.w_pready) begin
                lat = i;
                break;
            end
        end
        tick();
        tick();
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; wr = 1'b0; address = '0; wdata = '0;
        start_z = 1'b0; wr_z = 1'b0; address_z = '0; wdata_z = '0;
        hold_rdata = '0;
        for (int i = 0; i < MEM; i++) mem_m[i] = '0;

        repeat (5) tick();
        rst_n = 1'b1;
        tick();
        check("psel_after_reset", {31'b0, dut.w_psel}, 32'd0);
        check("rdata_after_reset", rdata, 32'd0);

        for (int i = 0; i < MEM; i++) issue(1'b0, i, 32'h0, 1, 1'b0);
        for (int i = 0; i < MEM; i++) issue(1'b1, i, 32'hDEAD_0000 + i, W + 3, 1'b1);
        for (int i = 0; i < MEM; i++) issue(1'b0, i, 32'h0, 1, 1'b0);

        // Out-of-range accesses must not alias onto word 0.
        issue(1'b1, 32, 32'hDEAD_0020, 1, 1'b0);
        issue(1'b0, 32, 32'h0, 1, 1'b0);
        issue(1'b0, 0, 32'h0, 1, 1'b0);
        issue(1'b0, 32'hFFFF_FFFF, 32'h0, 1, 1'b0);

        latency_check(9);

        issue(1'b0, 3, 32'h0, 20, 1'b0);

        // A second rising edge that arrives during ACCESS must be ignored.
        exp_q.push_back(predict(1'b0, 7, 32'h0));
        wr = 1'b0; address = 7; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        wr = 1'b1; wdata = 32'hBAD0_BAD0; start = 1'b1;
        tick(); start = 1'b0;
        wait_done();
        issue(1'b0, 7, 32'h0, 1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 35), $urandom,
                  $urandom_range(1, 8), 1'($urandom_range(0, 1)));
        end

        zop(1'b0, 31, 32'h0, lat);
        check("z_read_latency", lat, 32'd2);
        check("z_read_rdata", rdata_z, 32'd0);
        zop(1'b1, 2, 32'h1234_5678, lat);
        check("z_write_latency", lat, 32'd2);
        check("z_rdata_kept_on_write", rdata_z, 32'd0);
        zop(1'b0, 2, 32'h0, lat);
        check("z_readback", rdata_z, 32'h1234_5678);

        // Reset during ACCESS of a write to word 5 aborts the write and clears the memory.
        issue(1'b0, 5, 32'h0, 1, 1'b0);
        wr = 1'b1; address = 5; wdata = 32'hCAFE_F00D; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        check("in_access_before_reset", {31'b0, dut.w_penable}, 32'd1);
        rst_n = 1'b0;
        tick(); tick();
        check("psel_mid_reset", {31'b0, dut.w_psel}, 32'd0);
        check("rdata_mid_reset", rdata, 32'd0);
        exp_q.delete();
        hold_rdata = '0;
        for (int i = 0; i < MEM; i++) mem_m[i] = '0;
        // A start that is already high when reset releases counts as a request.
        wr = 1'b0; address = 5; start = 1'b1;
        exp_q.push_back(predict(1'b0, 5, 32'h0));
        rst_n = 1'b1;
        tick(); start = 1'b0;
        wait_done();
        issue(1'b0, 4, 32'h0, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
